bus_req_bridge: RTL and testbench
=================================

# bus_req_bridge

Clocked request front-end for the native parallel bus. Accepts read/write commands on a valid/ready port, buffers them in a small FIFO, and drives the shared `r_wn`/`addr`/`wdata` lines toward the bus endpoints. For each command it samples the OR-combined `rdata` after a fixed wait, checks the address against two decoded windows, and returns one response per command on a valid/ready port.

## Interface
- `ADDR_WIDTH`, 8: bus address width.
- `DATA_WIDTH`, 8: bus data width.
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `WAIT_CYCLES`, 2: extra cycles the bus is held before `rdata` is sampled (0..15).
- `BASE0`, 0 / `RANGE0`, 8: window 0 covers [BASE0, BASE0+RANGE0).
- `BASE1`, 32 / `RANGE1`, 128: window 1 covers [BASE1, BASE1+RANGE1).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: command present.
- `req_ready` out 1: FIFO can accept.
- `req_r_wn` in 1: 1 = read, 0 = write.
- `req_addr` in ADDR_WIDTH: command address.
- `req_wdata` in DATA_WIDTH: write data; ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and errors.
- `rsp_err` out 1: address outside both windows.
- `r_wn` out 1: bus direction.
- `addr` out ADDR_WIDTH: bus address.
- `wdata` out DATA_WIDTH: bus write data.
- `rdata` in DATA_WIDTH: OR of endpoint read data.
- `busy` out 1: FIFO non-empty or FSM not IDLE.

## Operation
- FIFO push on `req_valid && req_ready`. `req_ready = !full`. A pop in the same cycle does not free a slot for that cycle's push.
- Decode: `hit = (addr-BASE0 < RANGE0) || (addr-BASE1 < RANGE1)`. Compare as unsigned, widened by 1 bit so nothing wraps.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if FIFO is non-empty, pop the head.
    - Hit: load bus registers from the entry, set the counter to WAIT_CYCLES, go to ACCESS.
    - Miss: set `rsp_err=1` and `rsp_rdata=0`, leave the bus idle, go to RESP.
  - ACCESS: bus held stable. Decrement the counter each cycle. At counter==0:
    - capture `rdata` into `rsp_rdata` for reads; write 0 for writes;
    - return the bus to idle;
    - go to RESP.
  - RESP: `rsp_valid=1` and payload held stable until `rsp_ready`, then go to IDLE.
- Idle bus: `r_wn=1`, `addr=0`, `wdata=0`. A write never appears on the bus outside ACCESS.
- Exactly one command is outstanding on the bus. Responses return in command order.

## Timing
- Reset values:
  - `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`;
  - `r_wn=1`, `addr=0`, `wdata=0`, `busy=0`;
  - FIFO empty, state IDLE.
- All outputs are registered except `req_ready` and `busy`, which are derived combinationally from state registers only.
- A hit command pushed at edge E0 is popped at E1. The bus is driven from E1 through E1+WAIT_CYCLES+1, i.e. WAIT_CYCLES+1 cycles.
  - `rdata` is sampled at the last of those edges.
  - `rsp_valid` rises at E1+WAIT_CYCLES+1.
  - Push-to-response latency is WAIT_CYCLES+2 cycles.
- A miss has latency 2; the bus is never driven.
- With `rsp_ready` held high, back-to-back commands have throughput of 1 per WAIT_CYCLES+3 cycles.
- `rsp_ready` low stalls in RESP indefinitely. The FIFO keeps accepting until full.
- Reset in any state takes effect at the next edge:
  - bus returns to idle;
  - FIFO is flushed;
  - a pending response is dropped without a handshake.

## Structure
- Package `native_bus_pkg`: FSM state enum, `bus_cmd_t` struct {r_wn, addr, wdata}, and the idle-bus constants.
- Sub-module `sync_fifo`: parameterised width and depth, storing `bus_cmd_t`, with full/empty flags. The FSM and decode live in the top.

## Test plan
- Single read to 0x05 with endpoint 0 returning 0xA5 and WAIT_CYCLES=2 → `rsp_valid` 4 cycles after push, `rsp_rdata=0xA5`, `rsp_err=0`.
- Write 0x3C to 0x40 → `r_wn=0`, `addr=0x40`, `wdata=0x3C` for exactly 3 cycles, then a read of 0x40 returns 0x3C.
- Read 0x10 (gap between windows) and read 0xA0 (equal to BASE1+RANGE1) → `rsp_err=1`, `rsp_rdata=0`, bus stays idle, latency 2.
- Push 5 commands while `rsp_ready=0` → 4 accepted, `req_ready` low on the 5th; release `rsp_ready` → 5 responses in order, `busy` falls after the last.
- Assert `rst` mid-ACCESS of a write → next cycle `r_wn=1`, `addr=0`, FIFO empty, `rsp_valid=0`, no response ever emitted.

Source files
------------

// File: rtl/native_bus_pkg.sv
// Shared types and constants for the native parallel bus request path:
// FSM encoding, the command word carried through the FIFO, and the idle-bus value.
package native_bus_pkg;

    localparam int NB_ADDR_WIDTH = 8;
    localparam int NB_DATA_WIDTH = 8;
    localparam int CNT_WIDTH     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                     r_wn;
        logic [NB_ADDR_WIDTH-1:0] addr;
        logic [NB_DATA_WIDTH-1:0] wdata;
    } bus_cmd_t;

    localparam logic                     IDLE_R_WN  = 1'b1;
    localparam logic [NB_ADDR_WIDTH-1:0] IDLE_ADDR  = '0;
    localparam logic [NB_DATA_WIDTH-1:0] IDLE_WDATA = '0;

    localparam bus_cmd_t BUS_IDLE = '{r_wn: IDLE_R_WN, addr: IDLE_ADDR, wdata: IDLE_WDATA};

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of bus commands with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import native_bus_pkg::*;
#(
    parameter type T     = bus_cmd_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_push_data,
    input  logic i_pop,
    output T     o_pop_data,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    // Push is gated by the registered full flag only, so a same-cycle pop never frees a slot early.
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_full     = (r_count == (PW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    // NOTE: storage has no reset; the count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_req_bridge.sv
// Request front-end for the native parallel bus: queues commands, runs one bus access
// at a time with a fixed wait, and returns one in-order response per command.
module bus_req_bridge
    import native_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = NB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = NB_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE0       = 0,
    parameter int RANGE0      = 8,
    parameter int BASE1       = 32,
    parameter int RANGE1      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_r_wn,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  r_wn,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] BASE0_X  = (ADDR_WIDTH+1)'(BASE0);
    localparam logic [ADDR_WIDTH:0] RANGE0_X = (ADDR_WIDTH+1)'(RANGE0);
    localparam logic [ADDR_WIDTH:0] BASE1_X  = (ADDR_WIDTH+1)'(BASE1);
    localparam logic [ADDR_WIDTH:0] RANGE1_X = (ADDR_WIDTH+1)'(RANGE1);

    state_t                 r_state;
    bus_cmd_t               r_bus;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata;
    logic                   r_rsp_err;

    bus_cmd_t               w_cmd_in;
    bus_cmd_t               w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic [ADDR_WIDTH:0]    w_off0;
    logic [ADDR_WIDTH:0]    w_off1;
    logic                   w_hit;

    assign w_cmd_in = '{r_wn: req_r_wn, addr: req_addr, wdata: req_wdata};
    assign w_pop    = (r_state == ST_IDLE) && !w_empty;

    sync_fifo #(
        .T     (bus_cmd_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (req_valid),
        .i_push_data (w_cmd_in),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // One extra bit keeps addresses below a base from wrapping into the window.
    assign w_off0 = {1'b0, w_head.addr} - BASE0_X;
    assign w_off1 = {1'b0, w_head.addr} - BASE1_X;
    assign w_hit  = (w_off0 < RANGE0_X) || (w_off1 < RANGE1_X);

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bus       <= BUS_IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_hit) begin
                            r_bus     <= '{r_wn:  w_head.r_wn,
                                           addr:  w_head.addr,
                                           wdata: w_head.r_wn ? IDLE_WDATA : w_head.wdata};
                            r_cnt     <= CNT_WIDTH'(WAIT_CYCLES);
                            r_rsp_err <= 1'b0;
                            r_state   <= ST_ACCESS;
                        end else begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= r_bus.r_wn ? rdata : '0;
                        r_bus       <= BUS_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    // A miss enters RESP with valid still low, so it is raised here one cycle later.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = !w_full;
    assign busy      = !w_empty || (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign r_wn      = r_bus.r_wn;
    assign addr      = r_bus.addr;
    assign wdata     = r_bus.wdata;

endmodule

// File: tb/tb_bus_req_bridge.sv
// Directed bench for bus_req_bridge with a ROM endpoint in window 0 and a RAM endpoint
// in window 1 whose read data are OR-combined onto rdata.
module tb_bus_req_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_r_wn;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       r_wn;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram [0:127];

    always #5 clk = ~clk;

    bus_req_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_r_wn  (req_r_wn),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .r_wn      (r_wn),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy)
    );

    // Endpoint 0: ROM at 0x00..0x07 returning 0xA0|addr. Endpoint 1: RAM at 0x20..0x9F.
    always_comb begin
        rdata = 8'h00;
        if (r_wn && addr < 8'd8)
            rdata = rdata | (8'hA0 | addr);
        if (r_wn && addr >= 8'd32 && addr < 8'd160)
            rdata = rdata | ram[7'(addr - 8'd32)];
    end

    always @(posedge clk) begin
        if (!r_wn && addr >= 8'd32 && addr < 8'd160)
            ram[7'(addr - 8'd32)] <= wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b1000) begin
            $display("FAIL reset_flags: got ready/valid/err/busy=%b want 1000",
                     {req_ready, rsp_valid, rsp_err, busy});
            bad++;
        end
        total++;
        if (rsp_rdata !== 8'h00) begin
            $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata);
            bad++;
        end
        total++;
        if ({r_wn, addr, wdata} !== {1'b1, 8'h00, 8'h00}) begin
            $display("FAIL reset_bus: got r_wn=%b addr=%h wdata=%h want 1/00/00", r_wn, addr, wdata);
            bad++;
        end
    endtask

    // One read; hits respond after 4 edges, misses after 2 with the bus left idle.
    task automatic do_read(input logic [7:0] a, input logic exp_err,
                           input logic [7:0] exp_data, input int exp_lat);
        int  n;
        bit  bus_moved;
        n = 0;
        bus_moved = 1'b0;
        req_r_wn  = 1'b1;
        req_addr  = a;
        req_wdata = 8'h5A;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
            if (r_wn !== 1'b1 || addr !== 8'h00) bus_moved = 1'b1;
        end
        total++;
        if (n !== exp_lat) begin
            $display("FAIL rd_latency addr=%h: got %0d want %0d", a, n, exp_lat);
            bad++;
        end
        total++;
        if (rsp_err !== exp_err) begin
            $display("FAIL rd_err addr=%h: got %b want %b", a, rsp_err, exp_err);
            bad++;
        end
        total++;
        if (rsp_rdata !== exp_data) begin
            $display("FAIL rd_data addr=%h: got %h want %h", a, rsp_rdata, exp_data);
            bad++;
        end
        if (exp_err) begin
            total++;
            if (bus_moved) begin
                $display("FAIL miss_bus_idle addr=%h: got bus driven want idle", a);
                bad++;
            end
        end
        tick();
    endtask

    task automatic test_read;
        rsp_ready = 1'b1;
        do_read(8'h05, 1'b0, 8'hA5, 4);
        do_read(8'h07, 1'b0, 8'hA7, 4);
        do_read(8'h00, 1'b0, 8'hA0, 4);
    endtask

    task automatic test_write;
        int         n;
        int         wcnt;
        logic [7:0] seen_addr;
        logic [7:0] seen_wdata;
        n = 0;
        wcnt = 0;
        seen_addr  = 8'h00;
        seen_wdata = 8'h00;
        rsp_ready = 1'b1;
        req_r_wn  = 1'b0;
        req_addr  = 8'h40;
        req_wdata = 8'h3C;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
            if (r_wn === 1'b0) begin
                wcnt++;
                seen_addr  = addr;
                seen_wdata = wdata;
            end
        end
        total++;
        if (wcnt !== 3) begin
            $display("FAIL wr_bus_cycles: got %0d want 3", wcnt);
            bad++;
        end
        total++;
        if ({seen_addr, seen_wdata} !== 16'h403C) begin
            $display("FAIL wr_bus_value: got addr=%h wdata=%h want 40/3C", seen_addr, seen_wdata);
            bad++;
        end
        total++;
        if (n !== 4 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
            $display("FAIL wr_rsp: got lat=%0d err=%b rdata=%h want 4/0/00", n, rsp_err, rsp_rdata);
            bad++;
        end
        tick();
        do_read(8'h40, 1'b0, 8'h3C, 4);
    endtask

    task automatic test_decode;
        rsp_ready = 1'b1;
        do_read(8'h10, 1'b1, 8'h00, 2);
        do_read(8'hA0, 1'b1, 8'h00, 2);
        do_read(8'h08, 1'b1, 8'h00, 2);
        do_read(8'h1F, 1'b1, 8'h00, 2);
        do_read(8'h20, 1'b0, 8'h00, 4);
        do_read(8'h9F, 1'b0, 8'h00, 4);
    endtask

    task automatic test_back_to_back;
        logic       c_rw   [6];
        logic [7:0] c_addr [6];
        logic [7:0] c_wd   [6];
        logic       e_err  [6];
        logic [7:0] e_data [6];
        int         n;
        int         got;
        logic       acc;
        c_rw = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        c_addr = '{8'h01, 8'h41, 8'h41, 8'h10, 8'h03, 8'h41};
        c_wd = '{8'h00, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00};
        e_err = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        e_data = '{8'hA1, 8'h00, 8'h77, 8'h00, 8'hA3, 8'h77};

        rsp_ready = 1'b0;
        req_r_wn  = c_rw[0];
        req_addr  = c_addr[0];
        req_wdata = c_wd[0];
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 1; i < 5; i++) begin
            req_r_wn  = c_rw[i];
            req_addr  = c_addr[i];
            req_wdata = c_wd[i];
            req_valid = 1'b1;
            total++;
            if (req_ready !== 1'b1) begin
                $display("FAIL fill_ready[%0d]: got %b want 1", i, req_ready);
                bad++;
            end
            tick();
        end
        req_r_wn  = c_rw[5];
        req_addr  = c_addr[5];
        req_wdata = c_wd[5];
        req_valid = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b0) begin
            $display("FAIL full_ready: got %b want 0", req_ready);
            bad++;
        end
        total++;
        if ({rsp_valid, busy, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 8'hA1}) begin
            $display("FAIL stall_hold: got valid=%b busy=%b err=%b rdata=%h want 1/1/0/A1",
                     rsp_valid, busy, rsp_err, rsp_rdata);
            bad++;
        end

        got = 1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 200 && got < 6; c++) begin
            acc = req_valid && req_ready;
            tick();
            if (acc) req_valid = 1'b0;
            if (rsp_valid) begin
                total++;
                if (rsp_err !== e_err[got] || rsp_rdata !== e_data[got]) begin
                    $display("FAIL order[%0d]: got err=%b rdata=%h want %b/%h",
                             got, rsp_err, rsp_rdata, e_err[got], e_data[got]);
                    bad++;
                end
                got++;
            end
        end
        total++;
        if (got !== 6) begin
            $display("FAIL rsp_count: got %0d want 6", got);
            bad++;
        end
        req_valid = 1'b0;
        tick();
        total++;
        if ({busy, rsp_valid} !== 2'b00) begin
            $display("FAIL drain_busy: got busy=%b valid=%b want 0/0", busy, rsp_valid);
            bad++;
        end
    endtask

    task automatic test_reset_mid_access;
        int seen;
        seen = 0;
        rsp_ready = 1'b1;
        req_r_wn  = 1'b0;
        req_addr  = 8'h50;
        req_wdata = 8'h99;
        req_valid = 1'b1;
        tick();
        req_r_wn  = 1'b1;
        req_addr  = 8'h02;
        req_wdata = 8'h00;
        tick();
        req_valid = 1'b0;
        total++;
        if ({r_wn, addr, wdata} !== {1'b0, 8'h50, 8'h99}) begin
            $display("FAIL pre_rst_bus: got r_wn=%b addr=%h wdata=%h want 0/50/99", r_wn, addr, wdata);
            bad++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({r_wn, addr, wdata} !== {1'b1, 8'h00, 8'h00}) begin
            $display("FAIL rst_bus_idle: got r_wn=%b addr=%h wdata=%h want 1/00/00", r_wn, addr, wdata);
            bad++;
        end
        total++;
        if ({rsp_valid, busy, req_ready} !== 3'b001) begin
            $display("FAIL rst_flush: got valid=%b busy=%b ready=%b want 0/0/1", rsp_valid, busy, req_ready);
            bad++;
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid === 1'b1 || r_wn !== 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            $display("FAIL rst_no_rsp: got %0d active cycles want 0", seen);
            bad++;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 8'h00;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_r_wn  = 1'b1;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;

        test_reset();
        test_read();
        test_write();
        test_decode();
        test_back_to_back();
        test_reset_mid_access();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
